adsr_envelope_follower: RTL and testbench
=========================================

// Module: adsr_envelope_follower
// PURPOSE
//  Per-voice ADSR amplitude envelope for the synth voice path; the parametrised successor of the bare envelope stage.
//  Tracks note gate and velocity, advances a linear ADSR envelope once per sample strobe, scales each input sample by envelope*velocity.
//  Sits between oscillator output and voice mixer; one instance per voice.
// PARAMETERS
//  SAMPLE_W   12  sample width, signed two's complement
//  ENV_W      16  envelope accumulator / rate / sustain width (unsigned)
//  VEL_W       7  velocity width (MIDI)
// PORTS
//  inClk           in   1        system clock
//  inReset_n       in   1        synchronous reset, active low
//  inSample        in   SAMPLE_W signed input sample
//  inSampleReady   in   1        one-cycle sample strobe; may assert every cycle
//  inIsPlaying     in   1        note gate, level
//  inVelocity      in   VEL_W    note velocity, latched on gate rise
//  inAttackRate    in   ENV_W    envelope increment per strobe in ATTACK
//  inDecayRate     in   ENV_W    decrement per strobe in DECAY
//  inSustainLevel  in   ENV_W    sustain target level
//  inReleaseRate   in   ENV_W    decrement per strobe in RELEASE
//  outSample       out  SAMPLE_W scaled sample
//  outSampleReady  out  1        one-cycle strobe, valid outSample
//  outActive       out  1        1 when state != IDLE (voice allocator uses it)
// BEHAVIOUR
//  - Reset (inReset_n=0 at posedge): state=IDLE, env=0, velocity reg=0, gate history=0, pipeline valids=0;
//    outSample=0, outSampleReady=0, outActive=0. Reset mid-note aborts immediately, with no release tail.
//  - All state advances only on cycles with inSampleReady=1; gate is sampled on those cycles only.
//  - Gate rise (prev=0, now=1), from any state -> ATTACK; latch inVelocity; env is NOT cleared (retrigger from current level).
//  - Gate fall in ATTACK/DECAY/SUSTAIN -> RELEASE. Gate fall in IDLE/RELEASE: no effect.
//  - ATTACK:  env += inAttackRate, saturate at 2^ENV_W-1; on reaching max -> DECAY.
//  - DECAY:   env -= inDecayRate, floor at inSustainLevel; on reaching it -> SUSTAIN. If env <= sustain on entry -> SUSTAIN, env=sustain.
//  - SUSTAIN: env = inSustainLevel (tracks live changes).
//  - RELEASE: env -= inReleaseRate, floor 0; on reaching 0 -> IDLE.
//  - A rate input of 0 holds env (no transition); this is legal.
//  - All add/sub is ENV_W+1 wide, then saturated; no wrap-around ever.
//  - Gain for a sample uses env BEFORE that strobe's update.
//  - Pipeline: stage1 gain = (env * (vel+1)) >> VEL_W (ENV_W bits); stage2 out = (sample * gain) >>> ENV_W, signed, truncated to SAMPLE_W.
//  - Latency: outSampleReady exactly 2 cycles after inSampleReady; fully pipelined, back-to-back strobes are accepted.
//  - outSample holds its last value between strobes; in IDLE the output is 0 (env=0).
// CONFIGURATION
//  ENV_EXP_RELEASE_EN defined: RELEASE uses env -= max(env >> inReleaseRate[3:0], 1) (exponential tail);
//    inReleaseRate[ENV_W-1:4] is ignored; the state still reaches 0 and goes to IDLE.
//  Undefined: linear release as above. All other states are unaffected in both builds.
// STRUCTURE
//  - Shared package synth_pkg: env state encoding (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4), ENV_MAX constant.
//  - Sub-module env_gain_mult: 2-stage signed sample x unsigned gain multiplier with valid pipe; FSM plus accumulator stay in the top module.
// TESTING (SAMPLE_W=12, ENV_W=16, VEL_W=7)
//  1 Reset with gate=1 and strobes -> outSample=0, outSampleReady=0, outActive=0 throughout reset.
//  2 Attack=0x4000, vel=127, gate rise, sample=0x7FF held
//    -> env 0x4000, 0x8000, 0xC000, 0xFFFF over 4 strobes, then DECAY; outputs lag by one strobe; outSampleReady 2 cycles after each strobe.
//  3 Decay=0x1000, sustain=0x8000 -> reaches 0x8000 in 8 strobes, SUSTAIN; sustain changed to 0x4000 -> env=0x4000 next strobe.
//  4 Gate fall in SUSTAIN at 0x4000, release=0x2000 -> 0x2000, 0x0000, then IDLE, outActive=0; sample=-2048 gives outSample=0 after that.
//  5 Retrigger in RELEASE at env=0x3000 -> ATTACK from 0x3000, new velocity latched; vel=63 halves gain vs vel=127 (+/-1 LSB).
//  6 Strobe on every cycle for 20 cycles -> 20 outSampleReady pulses, none dropped; ENV_EXP_RELEASE_EN build: env 0x8000, shift 1 -> 0x4000, 0x2000, ...

Source files
------------

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Package  : synth_pkg
// Purpose  : Shared envelope state encoding and default widths for the voice path.
// Revision : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int SAMPLE_W_DEF = 12;
    localparam int ENV_W_DEF    = 16;
    localparam int VEL_W_DEF    = 7;

    localparam logic [ENV_W_DEF-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } envState_t;

    // States in which a gate fall starts the release tail.
    function automatic logic isGated(input envState_t s);
        return (s == ENV_ATTACK) || (s == ENV_DECAY) || (s == ENV_SUSTAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adsr_envelope_follower_if.sv
`default_nettype none
// ============================================================================
// Interface: adsr_envelope_follower_if
// Purpose  : Sample stream, note control and envelope settings of one voice.
// Revision : 1.0 - initial release
// ============================================================================
interface adsr_envelope_follower_if #(
    parameter int SAMPLE_W = 12,
    parameter int ENV_W    = 16,
    parameter int VEL_W    = 7
) ();
    logic signed [SAMPLE_W-1:0] inSample;
    logic                       inSampleReady;
    logic                       inIsPlaying;
    logic        [VEL_W-1:0]    inVelocity;
    logic        [ENV_W-1:0]    inAttackRate;
    logic        [ENV_W-1:0]    inDecayRate;
    logic        [ENV_W-1:0]    inSustainLevel;
    logic        [ENV_W-1:0]    inReleaseRate;
    logic signed [SAMPLE_W-1:0] outSample;
    logic                       outSampleReady;
    logic                       outActive;

    modport master (
        output inSample, inSampleReady, inIsPlaying, inVelocity,
               inAttackRate, inDecayRate, inSustainLevel, inReleaseRate,
        input  outSample, outSampleReady, outActive
    );

    modport slave (
        input  inSample, inSampleReady, inIsPlaying, inVelocity,
               inAttackRate, inDecayRate, inSustainLevel, inReleaseRate,
        output outSample, outSampleReady, outActive
    );
endinterface
`default_nettype wire

// File: rtl/adsr_envelope_follower_gain_mult.sv
`default_nettype none
// ============================================================================
// Module   : env_gain_mult
// Purpose  : Two-stage sample x (env*velocity) multiplier with valid pipe.
// Revision : 1.0 - initial release
// ============================================================================
module env_gain_mult #(
    parameter int SAMPLE_W = 12,
    parameter int ENV_W    = 16,
    parameter int VEL_W    = 7
) (
    input  logic                       inClk,
    input  logic                       inReset_n,
    input  logic                       inValid,
    input  logic signed [SAMPLE_W-1:0] inSample,
    input  logic        [ENV_W-1:0]    inEnv,
    input  logic        [VEL_W-1:0]    inVelocity,
    output logic                       outValid,
    output logic signed [SAMPLE_W-1:0] outSample
);
    logic [ENV_W+VEL_W:0]         w_envExt;
    logic [ENV_W+VEL_W:0]         w_velExt;
    logic [ENV_W+VEL_W:0]         w_scaled;
    logic [ENV_W-1:0]             w_gain;
    logic signed [SAMPLE_W+ENV_W:0] w_product;

    logic                         r_valid1;
    logic                         r_valid2;
    logic [ENV_W-1:0]             r_gain;
    logic signed [SAMPLE_W-1:0]   r_sample1;
    logic signed [SAMPLE_W-1:0]   r_out;

    // vel+1 makes full velocity a unity multiplier after the >> VEL_W.
    assign w_envExt = {{(VEL_W+1){1'b0}}, inEnv};
    assign w_velExt = {{(ENV_W+1){1'b0}}, inVelocity} + {{(ENV_W+VEL_W){1'b0}}, 1'b1};
    assign w_scaled = w_envExt * w_velExt;
    assign w_gain   = ENV_W'(w_scaled >> VEL_W);

    assign w_product = $signed({{(ENV_W+1){r_sample1[SAMPLE_W-1]}}, r_sample1})
                     * $signed({{(SAMPLE_W+1){1'b0}}, r_gain});

    always_ff @(posedge inClk) begin
        if (!inReset_n) begin
            r_valid1  <= 1'b0;
            r_valid2  <= 1'b0;
            r_gain    <= '0;
            r_sample1 <= '0;
            r_out     <= '0;
        end else begin
            r_valid1 <= inValid;
            r_valid2 <= r_valid1;
            if (inValid) begin
                r_gain    <= w_gain;
                r_sample1 <= inSample;
            end
            if (r_valid1) begin
                r_out <= SAMPLE_W'(w_product >>> ENV_W);
            end
        end
    end

    assign outValid  = r_valid2;
    assign outSample = r_out;
endmodule
`default_nettype wire

// File: rtl/adsr_envelope_follower.sv
`default_nettype none
// ============================================================================
// Module   : adsr_envelope_follower
// Purpose  : Per-voice ADSR envelope advanced per sample strobe; scales samples.
//            Define ENV_EXP_RELEASE_EN for an exponential release tail.
// Revision : 1.0 - initial release
// ============================================================================
module adsr_envelope_follower
    import synth_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ENV_W    = ENV_W_DEF,
    parameter int VEL_W    = VEL_W_DEF
) (
    input  logic                    inClk,
    input  logic                    inReset_n,
    adsr_envelope_follower_if.slave bus
);
    localparam logic [ENV_W:0] c_envMax = {1'b0, {ENV_W{1'b1}}};

    envState_t                  r_state;
    envState_t                  w_effState;
    envState_t                  w_nextState;
    logic [ENV_W-1:0]           r_env;
    logic [ENV_W-1:0]           w_nextEnv;
    logic [ENV_W-1:0]           w_relStep;
    logic [VEL_W-1:0]           r_vel;
    logic                       r_gatePrev;
    logic                       w_gateRise;
    logic                       w_gateFall;
    logic [ENV_W:0]             w_attackSum;
    logic [ENV_W:0]             w_decayDiff;
    logic [ENV_W:0]             w_relDiff;
    logic                       w_outValid;
    logic signed [SAMPLE_W-1:0] w_outSample;

    assign w_gateRise = bus.inIsPlaying & ~r_gatePrev;
    assign w_gateFall = ~bus.inIsPlaying & r_gatePrev;

    // One extra bit so overflow/borrow is visible before saturating.
    assign w_attackSum = {1'b0, r_env} + {1'b0, bus.inAttackRate};
    assign w_decayDiff = {1'b0, r_env} - {1'b0, bus.inDecayRate};

`ifdef ENV_EXP_RELEASE_EN
    logic [ENV_W-1:0] w_expStep;
    assign w_expStep = r_env >> bus.inReleaseRate[3:0];
    assign w_relStep = (w_expStep == '0) ? {{(ENV_W-1){1'b0}}, 1'b1} : w_expStep;
`else
    assign w_relStep = bus.inReleaseRate;
`endif
    assign w_relDiff = {1'b0, r_env} - {1'b0, w_relStep};

    always_comb begin
        w_effState  = r_state;
        w_nextState = r_state;
        w_nextEnv   = r_env;
        // Gate edges pick the state whose step is applied on this same strobe.
        if (w_gateRise) begin
            w_effState = ENV_ATTACK;
        end else if (w_gateFall && isGated(r_state)) begin
            w_effState = ENV_RELEASE;
        end
        w_nextState = w_effState;
        case (w_effState)
            ENV_ATTACK: begin
                if (w_attackSum >= c_envMax) begin
                    w_nextEnv   = c_envMax[ENV_W-1:0];
                    w_nextState = ENV_DECAY;
                end else begin
                    w_nextEnv = w_attackSum[ENV_W-1:0];
                end
            end
            ENV_DECAY: begin
                if (w_decayDiff[ENV_W] || (w_decayDiff[ENV_W-1:0] <= bus.inSustainLevel)) begin
                    w_nextEnv   = bus.inSustainLevel;
                    w_nextState = ENV_SUSTAIN;
                end else begin
                    w_nextEnv = w_decayDiff[ENV_W-1:0];
                end
            end
            ENV_SUSTAIN: begin
                w_nextEnv = bus.inSustainLevel;
            end
            ENV_RELEASE: begin
                if (w_relDiff[ENV_W] || (w_relDiff[ENV_W-1:0] == '0)) begin
                    w_nextEnv   = '0;
                    w_nextState = ENV_IDLE;
                end else begin
                    w_nextEnv = w_relDiff[ENV_W-1:0];
                end
            end
            default: begin
                w_nextEnv = r_env;
            end
        endcase
    end

    always_ff @(posedge inClk) begin
        if (!inReset_n) begin
            r_state    <= ENV_IDLE;
            r_env      <= '0;
            r_vel      <= '0;
            r_gatePrev <= 1'b0;
        end else if (bus.inSampleReady) begin
            r_state    <= w_nextState;
            r_env      <= w_nextEnv;
            r_gatePrev <= bus.inIsPlaying;
            if (w_gateRise) begin
                r_vel <= bus.inVelocity;
            end
        end
    end

    // Gain is taken from env/velocity as they stood before this strobe.
    env_gain_mult #(
        .SAMPLE_W (SAMPLE_W),
        .ENV_W    (ENV_W),
        .VEL_W    (VEL_W)
    ) u_gainMult (
        .inClk      (inClk),
        .inReset_n  (inReset_n),
        .inValid    (bus.inSampleReady),
        .inSample   (bus.inSample),
        .inEnv      (r_env),
        .inVelocity (r_vel),
        .outValid   (w_outValid),
        .outSample  (w_outSample)
    );

    assign bus.outSample      = w_outSample;
    assign bus.outSampleReady = w_outValid;
    assign bus.outActive      = (r_state != ENV_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope_follower.sv
`default_nettype none
// ============================================================================
// Module   : tb_adsr_envelope_follower
// Purpose  : Self-checking bench for adsr_envelope_follower (both release builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope_follower;
    localparam int M_IDLE    = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_DECAY   = 2;
    localparam int M_SUSTAIN = 3;
    localparam int M_RELEASE = 4;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nErrors;
    int   pulseCount;
    int   gotOuts[$];

    // Reference envelope and output expectation, kept as plain integers.
    int   mState;
    int   mEnv;
    int   mVel;
    bit   mPrev;
    bit   pendValid;
    int   pendOut;
    bit   expValid;
    int   expOut;

    adsr_envelope_follower_if bus ();

    adsr_envelope_follower dut (
        .inClk     (clk),
        .inReset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int s;
        int nxt;
        int step;
        bit gate;
        if (!rst_n) begin
            mState = M_IDLE; mEnv = 0; mVel = 0; mPrev = 1'b0;
            pendValid = 1'b0; pendOut = 0; expValid = 1'b0; expOut = 0;
        end else begin
            expValid = pendValid;
            if (pendValid) expOut = pendOut;
            pendValid = bus.inSampleReady;
            if (bus.inSampleReady) begin
                s = bus.inSample;
                pendOut = (s * ((mEnv * (mVel + 1)) >> 7)) >>> 16;
                gate = bus.inIsPlaying;
                if (gate && !mPrev) begin
                    mState = M_ATTACK;
                    mVel   = bus.inVelocity;
                end else if (!gate && mPrev && (mState inside {M_ATTACK, M_DECAY, M_SUSTAIN})) begin
                    mState = M_RELEASE;
                end
                mPrev = gate;
                case (mState)
                    M_ATTACK: begin
                        nxt = mEnv + int'(bus.inAttackRate);
                        if (nxt >= 65535) begin mEnv = 65535; mState = M_DECAY; end
                        else mEnv = nxt;
                    end
                    M_DECAY: begin
                        nxt = mEnv - int'(bus.inDecayRate);
                        if (nxt <= int'(bus.inSustainLevel)) begin
                            mEnv = bus.inSustainLevel; mState = M_SUSTAIN;
                        end else mEnv = nxt;
                    end
                    M_SUSTAIN: mEnv = bus.inSustainLevel;
                    M_RELEASE: begin
`ifdef ENV_EXP_RELEASE_EN
                        step = mEnv >> (int'(bus.inReleaseRate) & 15);
                        if (step < 1) step = 1;
`else
                        step = bus.inReleaseRate;
`endif
                        nxt = mEnv - step;
                        if (nxt <= 0) begin mEnv = 0; mState = M_IDLE; end
                        else mEnv = nxt;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("outSampleReady", bus.outSampleReady, expValid);
        check("outSample", bus.outSample, expOut);
        check("outActive", bus.outActive, (mState != M_IDLE));
        if (bus.outSampleReady === 1'b1) begin
            gotOuts.push_back(bus.outSample);
            pulseCount++;
        end
    end

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); bus.inSampleReady = 1'b1;
            @(negedge clk); bus.inSampleReady = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        nChecks = 0; nErrors = 0; pulseCount = 0;
        rst_n = 1'b0;
        bus.inSampleReady  = 1'b0;
        bus.inIsPlaying    = 1'b1;
        bus.inSample       = 12'sh7FF;
        bus.inVelocity     = 7'd127;
        bus.inAttackRate   = 16'h4000;
        bus.inDecayRate    = 16'h1000;
        bus.inSustainLevel = 16'h8000;
        bus.inReleaseRate  = 16'h2000;

        // Reset held with gate high and strobes toggling.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus.inSampleReady = ~bus.inSampleReady;
        end
        @(negedge clk);
        bus.inSampleReady = 1'b0; bus.inIsPlaying = 1'b0; rst_n = 1'b1;
        run(1);

        // Attack from zero at full velocity.
        gotOuts.delete();
        bus.inIsPlaying = 1'b1;
        run(4);
        check("t2 env", mEnv, 32'hFFFF);
        check("t2 state", mState, M_DECAY);
        check("t2 out0", gotOuts[0], 0);
        check("t2 out1", gotOuts[1], 511);
        check("t2 out3", gotOuts[3], 1535);

        // Decay to sustain, then live sustain change.
        gotOuts.delete();
        run(8);
        check("t3 env", mEnv, 32'h8000);
        check("t3 state", mState, M_SUSTAIN);
        check("t3 out0", gotOuts[0], 2046);
        check("t3 out7", gotOuts[7], 1151);
        bus.inSustainLevel = 16'h4000;
        gotOuts.delete();
        run(1);
        check("t3 sus env", mEnv, 32'h4000);
        check("t3 sus out", gotOuts[0], 1023);

        // Release to idle with a negative full-scale sample.
        gotOuts.delete();
        bus.inIsPlaying = 1'b0;
        bus.inSample    = 12'sh800;
        run(3);
        check("t4 state", mState, M_IDLE);
        check("t4 active", bus.outActive, 0);
        check("t4 out0", gotOuts[0], -512);
`ifdef ENV_EXP_RELEASE_EN
        check("t4 out1", gotOuts[1], 0);
`else
        check("t4 out1", gotOuts[1], -256);
`endif
        check("t4 out2", gotOuts[2], 0);

        // Retrigger during release with a lower velocity.
        gotOuts.delete();
        bus.inSample = 12'sh7FF; bus.inIsPlaying = 1'b1; bus.inAttackRate = 16'h3000;
        run(1);
        bus.inIsPlaying = 1'b0;
`ifdef ENV_EXP_RELEASE_EN
        bus.inReleaseRate = 16'h000F;
`else
        bus.inReleaseRate = 16'h0000;
`endif
        run(1);
        check("t5 rel state", mState, M_RELEASE);
        bus.inIsPlaying = 1'b1; bus.inVelocity = 7'd63; bus.inAttackRate = 16'h0000;
        run(2);
`ifdef ENV_EXP_RELEASE_EN
        check("t5 env", mEnv, 32'h2FFF);
`else
        check("t5 env", mEnv, 32'h3000);
`endif
        check("t5 state", mState, M_ATTACK);
        check("t5 vel", mVel, 63);
        check("t5 out1", gotOuts[1], 383);
        check("t5 out2", gotOuts[2], 383);
        check("t5 out3", gotOuts[3], 191);

        // Back-to-back strobes with a changing sample.
        bus.inAttackRate = 16'h1000;
        pulseCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.inSampleReady = 1'b1;
            bus.inSample      = 12'(i * 100 - 1000);
        end
        @(negedge clk); bus.inSampleReady = 1'b0;
        repeat (3) @(negedge clk);
        check("t6 pulses", pulseCount, 20);

        // Reset mid-note aborts without a release tail.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.inSampleReady = ~bus.inSampleReady;
        end
        @(negedge clk);
        bus.inSampleReady = 1'b0; bus.inIsPlaying = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("reset active", bus.outActive, 0);
        check("reset out", bus.outSample, 0);

        // Release shape from 0x8000 with rate 1.
        gotOuts.delete();
        bus.inSample = 12'sh7FF; bus.inVelocity = 7'd127;
        bus.inIsPlaying = 1'b1; bus.inAttackRate = 16'h8000;
        run(1);
        check("t7 env", mEnv, 32'h8000);
        bus.inIsPlaying = 1'b0; bus.inReleaseRate = 16'h0001;
        run(3);
`ifdef ENV_EXP_RELEASE_EN
        check("t7 rel env", mEnv, 32'h1000);
        check("t7 out3", gotOuts[3], 255);
`else
        check("t7 rel env", mEnv, 32'h7FFD);
        check("t7 out3", gotOuts[3], 1023);
`endif
        check("t7 out1", gotOuts[1], 1023);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
`default_nettype wire
